// File: rtl/cond_flag_unit.sv
// Condition-flag unit: live/saved {N,Z,C,V} registers with exception save/restore,
// plus a one-deep response slot that evaluates ARM condition codes against forwarded flags.
module cond_flag_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] flag_in,
  input  logic       flag_we,
  input  logic       exc_save,
  input  logic       exc_restore,
  input  logic       req_valid,
  input  logic [3:0] req_cond,
  output logic       req_ready,
  output logic       resp_valid,
  output logic       resp_pass,
  input  logic       resp_ready,
  output logic [3:0] flags,
  output logic [3:0] saved_flags,
  output logic       carry_out
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     state;
  logic [3:0] flags_nxt;
  logic       accept;
  logic       pass_p0;

  // Even condition codes are the base test; odd codes are its complement,
  // which also makes AL(E)=1 and NV(F)=0 fall out of the default row.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return cond[0] ? ~base : base;
  endfunction

  always_comb begin
    flags_nxt = flags;
    if (exc_restore)  flags_nxt = saved_flags;
    else if (flag_we) flags_nxt = flag_in;
  end

  assign resp_valid = (state == FULL);
  assign req_ready  = ~resp_valid | resp_ready;
  assign accept     = req_valid & req_ready;
  assign carry_out  = flags[1];
  assign pass_p0    = cond_eval(req_cond, flags_nxt);

  // Stage p0 -> response slot: result captured on accept, held through stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      resp_pass   <= 1'b0;
      flags       <= 4'b0000;
      saved_flags <= 4'b0000;
    end else begin
      flags <= flags_nxt;
      if (exc_save) saved_flags <= flags;
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= FULL;
            resp_pass <= pass_p0;
          end
        end
        FULL: begin
          if (accept) begin
            resp_pass <= pass_p0;
          end else if (resp_ready) begin
            state     <= EMPTY;
            resp_pass <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          resp_pass <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: flag register priority, save/restore,
// response slot handshake, forwarding and the full condition table.
module tb_cond_flag_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] flag_in;
  logic       flag_we;
  logic       exc_save;
  logic       exc_restore;
  logic       req_valid;
  logic [3:0] req_cond;
  logic       req_ready;
  logic       resp_valid;
  logic       resp_pass;
  logic       resp_ready;
  logic [3:0] flags;
  logic [3:0] saved_flags;
  logic       carry_out;

  int errors = 0;
  int checks = 0;

  cond_flag_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flag_in     (flag_in),
    .flag_we     (flag_we),
    .exc_save    (exc_save),
    .exc_restore (exc_restore),
    .req_valid   (req_valid),
    .req_cond    (req_cond),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_pass   (resp_pass),
    .resp_ready  (resp_ready),
    .flags       (flags),
    .saved_flags (saved_flags),
    .carry_out   (carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Straight transcription of the ARM condition table, N,Z,C,V = f[3:0].
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle();
    flag_we = 0; exc_save = 0; exc_restore = 0; req_valid = 0;
  endtask

  initial begin
    rst_n = 0; flag_in = 4'b1111; flag_we = 1; exc_save = 1; exc_restore = 1;
    req_valid = 1; req_cond = 4'hE; resp_ready = 0;
    step(); step();
    check("rst_flags", flags, 4'b0000);
    check("rst_saved", saved_flags, 4'b0000);
    check("rst_valid", resp_valid, 0);
    check("rst_pass", resp_pass, 0);
    idle(); rst_n = 1; #1;
    check("rst_ready", req_ready, 1);

    // Flag write forwarded into an EQ check in the same cycle
    flag_we = 1; flag_in = 4'b0100; req_valid = 1; req_cond = 4'h0; resp_ready = 1;
    step();
    check("fwd_flags", flags, 4'b0100);
    check("fwd_valid", resp_valid, 1);
    check("fwd_pass", resp_pass, 1);

    // Drain slot while loading N=1,V=1
    idle(); flag_we = 1; flag_in = 4'b1001;
    step();
    check("drain_valid", resp_valid, 0);
    check("drain_pass0", resp_pass, 0);

    // Back-to-back GE, LT, GT
    idle(); req_valid = 1; req_cond = 4'hA;
    step();
    check("b2b_ge", resp_pass, 1);
    check("b2b_rdy0", req_ready, 1);
    req_cond = 4'hB;
    step();
    check("b2b_lt", resp_pass, 0);
    check("b2b_rdy1", req_ready, 1);
    check("b2b_vld1", resp_valid, 1);
    req_cond = 4'hC;
    step();
    check("b2b_gt", resp_pass, 1);
    check("b2b_rdy2", req_ready, 1);
    idle();
    step();
    check("b2b_empty", resp_valid, 0);

    // Stall: GE passes, then flags change so GE would fail
    req_valid = 1; req_cond = 4'hA; resp_ready = 0;
    step();
    check("stall_vld", resp_valid, 1);
    check("stall_pass", resp_pass, 1);
    req_valid = 1; req_cond = 4'hB; flag_we = 1; flag_in = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_rdy", req_ready, 0);
      step();
      check("stall_hold", resp_pass, 1);
      check("stall_vldh", resp_valid, 1);
      flag_in = (i == 0) ? 4'b0001 : 4'b1000;
    end
    check("stall_flags", flags, 4'b1000);
    idle(); resp_ready = 1; #1;
    check("stall_rdy1", req_ready, 1);
    step();
    check("stall_drain", resp_valid, 0);
    check("stall_pass0", resp_pass, 0);

    // Save / restore
    flag_we = 1; flag_in = 4'b0010;
    step();
    idle(); exc_save = 1;
    step();
    check("save", saved_flags, 4'b0010);
    idle(); flag_we = 1; flag_in = 4'b1000;
    step();
    check("we_after_save", flags, 4'b1000);
    check("carry0", carry_out, 0);
    idle(); exc_restore = 1;
    step();
    check("restore", flags, 4'b0010);
    check("carry1", carry_out, 1);
    idle(); flag_in = 4'b0000; #1;
    check("carry_reg_only", carry_out, 1);
    flag_we = 1; flag_in = 4'b0001;
    step();
    idle(); exc_save = 1; exc_restore = 1;
    step();
    check("swap_live", flags, 4'b0010);
    check("swap_saved", saved_flags, 4'b0001);
    idle(); exc_save = 1; flag_we = 1; flag_in = 4'b1111;
    step();
    check("save_we_saved", saved_flags, 4'b0010);
    check("save_we_live", flags, 4'b1111);
    idle(); exc_restore = 1; flag_we = 1; flag_in = 4'b0100;
    step();
    check("rest_prio", flags, 4'b0010);

    // Full condition table, flags forwarded via flag_we in the accept cycle
    idle(); resp_ready = 1;
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        flag_we = 1; flag_in = 4'(f); req_valid = 1; req_cond = 4'(c);
        step();
        check($sformatf("cond_c%0h_f%0h", c, f), resp_pass, ref_cond(4'(c), 4'(f)));
      end
    end
    idle();
    step();

    // Reset during a stalled response
    flag_we = 1; flag_in = 4'b1010; exc_save = 1; req_valid = 1; req_cond = 4'hE; resp_ready = 0;
    step();
    check("pre_rst_vld", resp_valid, 1);
    idle(); rst_n = 0; req_valid = 1; flag_we = 1; flag_in = 4'b1111;
    step();
    check("rst_stall_vld", resp_valid, 0);
    check("rst_stall_pass", resp_pass, 0);
    check("rst_stall_flags", flags, 4'b0000);
    check("rst_stall_saved", saved_flags, 4'b0000);
    idle(); rst_n = 1; #1;
    check("rst_stall_rdy", req_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
